// File: rtl/and_stim_sequencer.sv
// and_stim_sequencer
// Stimulus/response sequencer for a two-input AND cell.
//
// The block steps through every WIDTH-bit vector in counting order and holds
// each one for HOLD cycles. In the last cycle of each hold window it samples
// the cell output f_in and compares it with the expected AND-reduction of the
// driven vector. A failed compare gives a one-cycle mismatch pulse on the
// following cycle and bumps a saturating error counter. The whole vector space
// is swept LOOPS times, and then the block parks in DONE until the next start.
//
// The registered expected value is exported as expect_val, because "expect"
// is a reserved word in SystemVerilog. expect_val always equals &vec in the
// same cycle.
//
// Reset is asynchronous and active-low. All outputs come straight from
// registers, so a reset clears them immediately without waiting for clk.

module and_stim_sequencer #(
    parameter int WIDTH = 2,    // vector width driven to the cell (1..16)
    parameter int HOLD  = 20,   // cycles each vector is held (>= 1)
    parameter int LOOPS = 1,    // full passes over all 2^WIDTH vectors (>= 1)
    parameter int ERRW  = 16    // width of the saturating error counter (>= 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] vec,
    output logic             vec_valid,
    input  logic             f_in,
    output logic             expect_val,
    output logic             mismatch,
    output logic [ERRW-1:0]  err_count,
    output logic             busy,
    output logic             done
);

    // Counter widths. Both are kept at least one bit wide, so that HOLD=1 or
    // LOOPS=1 still gives a legal (constant-zero) counter.
    localparam int HW = (HOLD  > 1) ? $clog2(HOLD)  : 1;
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Registered state and outputs
    state_t           state_reg,     state_next;
    logic [WIDTH-1:0] vec_reg,       vec_next;
    logic             valid_reg,     valid_next;
    logic             expect_reg,    expect_next;
    logic             mismatch_reg,  mismatch_next;
    logic [ERRW-1:0]  err_reg,       err_next;
    logic             busy_reg,      busy_next;
    logic             done_reg,      done_next;
    logic [HW-1:0]    hold_reg,      hold_next;
    logic [LW-1:0]    loop_reg,      loop_next;

    // Decoded conditions used by the next-state logic
    logic sample_edge;   // this edge closes the current hold window
    logic sample_fail;   // the cell output disagrees with the expected value
    logic vec_last;      // the current vector is all ones
    logic loop_last;     // the current pass is the final one
    logic err_full;      // the error counter has reached its ceiling

    assign sample_edge = (hold_reg == HOLD_LAST);
    assign sample_fail = (f_in != expect_reg);
    assign vec_last    = &vec_reg;
    assign loop_last   = (loop_reg == LOOP_LAST);
    assign err_full    = &err_reg;

    // State and output registers, with an asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            vec_reg      <= '0;
            valid_reg    <= 1'b0;
            expect_reg   <= 1'b0;
            mismatch_reg <= 1'b0;
            err_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            hold_reg     <= '0;
            loop_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            vec_reg      <= vec_next;
            valid_reg    <= valid_next;
            expect_reg   <= expect_next;
            mismatch_reg <= mismatch_next;
            err_reg      <= err_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            hold_reg     <= hold_next;
            loop_reg     <= loop_next;
        end
    end

    // Next-state logic: start/stop handling, hold timing, vector stepping,
    // and the compare
    always_comb begin
        // Everything holds by default, and mismatch is a single-cycle pulse.
        state_next    = state_reg;
        vec_next      = vec_reg;
        valid_next    = valid_reg;
        mismatch_next = 1'b0;
        err_next      = err_reg;
        busy_next     = busy_reg;
        done_next     = done_reg;
        hold_next     = hold_reg;
        loop_next     = loop_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                // stop blocks a simultaneous start; on its own it does nothing here.
                if (start && !stop) begin
                    state_next = S_RUN;
                    vec_next   = '0;
                    valid_next = 1'b1;
                    busy_next  = 1'b1;
                    done_next  = 1'b0;
                    err_next   = '0;
                    hold_next  = '0;
                    loop_next  = '0;
                end
            end

            S_RUN: begin
                if (stop) begin
                    // An abort discards any compare due on this edge but keeps
                    // the errors counted so far visible.
                    state_next = S_IDLE;
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                    hold_next  = '0;
                end else if (sample_edge) begin
                    if (sample_fail) begin
                        mismatch_next = 1'b1;
                        if (!err_full) begin
                            err_next = err_reg + 1'b1;
                        end
                    end
                    hold_next = '0;
                    if (!vec_last) begin
                        vec_next = vec_reg + 1'b1;
                    end else if (!loop_last) begin
                        // Wrap straight into the next pass, with no idle gap.
                        vec_next  = '0;
                        loop_next = loop_reg + 1'b1;
                    end else begin
                        // Final vector of the final pass. vec keeps its last
                        // value so the last stimulus can still be inspected.
                        state_next = S_DONE;
                        valid_next = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end else begin
                    hold_next = hold_reg + 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // The expected value tracks the vector that is registered on this edge.
        expect_next = &vec_next;
    end

    assign vec        = vec_reg;
    assign vec_valid  = valid_reg;
    assign expect_val = expect_reg;
    assign mismatch   = mismatch_reg;
    assign err_count  = err_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_and_stim_sequencer.sv
// tb_and_stim_sequencer
// Directed bench for and_stim_sequencer. It uses three instances:
//   u_a: WIDTH=2, HOLD=20, LOOPS=1. Covers the fault-free run, a stuck-at-1
//        cell, abort/restart, asynchronous reset and start/stop priority.
//   u_b: WIDTH=2, HOLD=1, LOOPS=3. Covers loop wrap-around.
//   u_c: WIDTH=5, HOLD=1, LOOPS=1, ERRW=4. Covers error-counter saturation.
// Inputs are driven, and outputs sampled, on the falling clock edge.

module tb_and_stim_sequencer;

    logic clk;
    logic rst_n;

    // Instance A signals
    logic        start_a, stop_a, stuck_a, f_in_a;
    logic [1:0]  vec_a;
    logic        valid_a, exp_a, mm_a, busy_a, done_a;
    logic [15:0] err_a;

    // Instance B signals
    logic        start_b, stop_b, f_in_b;
    logic [1:0]  vec_b;
    logic        valid_b, exp_b, mm_b, busy_b, done_b;
    logic [15:0] err_b;

    // Instance C signals
    logic        start_c, stop_c, f_in_c;
    logic [4:0]  vec_c;
    logic        valid_c, exp_c, mm_c, busy_c, done_c;
    logic [3:0]  err_c;

    int vectors;
    int miscompares;

    // Cell models. A can be forced to a stuck-at-1 output; C is always wrong.
    assign f_in_a = stuck_a ? 1'b1 : (vec_a[1] & vec_a[0]);
    assign f_in_b = vec_b[1] & vec_b[0];
    assign f_in_c = ~(&vec_c);

    and_stim_sequencer #(.WIDTH(2), .HOLD(20), .LOOPS(1), .ERRW(16)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
        .vec(vec_a), .vec_valid(valid_a), .f_in(f_in_a), .expect_val(exp_a),
        .mismatch(mm_a), .err_count(err_a), .busy(busy_a), .done(done_a)
    );

    and_stim_sequencer #(.WIDTH(2), .HOLD(1), .LOOPS(3), .ERRW(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
        .vec(vec_b), .vec_valid(valid_b), .f_in(f_in_b), .expect_val(exp_b),
        .mismatch(mm_b), .err_count(err_b), .busy(busy_b), .done(done_b)
    );

    and_stim_sequencer #(.WIDTH(5), .HOLD(1), .LOOPS(1), .ERRW(4)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .stop(stop_c),
        .vec(vec_c), .vec_valid(valid_c), .f_in(f_in_c), .expect_val(exp_c),
        .mismatch(mm_c), .err_count(err_c), .busy(busy_c), .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full A run: start pulse, then 80 held cycles, then check the DONE state.
    task automatic run_a(input int exp_err, input int exp_first);
        int mm_seen;
        int first_mm;
        mm_seen  = 0;
        first_mm = -1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("a_start_busy",  busy_a,  1);
        check("a_start_valid", valid_a, 1);
        for (int c = 0; c < 80; c++) begin
            check("a_vec",      vec_a,  c / 20);
            check("a_expect",   exp_a,  ((c / 20) == 3) ? 1 : 0);
            check("a_busy_run", busy_a, 1);
            check("a_done_low", done_a, 0);
            if (mm_a) begin
                mm_seen++;
                if (first_mm < 0) first_mm = c;
            end
            @(negedge clk);
        end
        if (mm_a) mm_seen++;
        check("a_done",       done_a,   1);
        check("a_done_busy",  busy_a,   0);
        check("a_done_valid", valid_a,  0);
        check("a_done_vec",   vec_a,    3);
        check("a_err",        err_a,    exp_err);
        check("a_mm_pulses",  mm_seen,  exp_err);
        check("a_first_mm",   first_mm, exp_first);
        $display("run A: err_count=%0d pulses=%0d first=%0d", err_a, mm_seen, first_mm);
    endtask

    initial begin
        int mm_seen;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start_a = 1'b0; stop_a = 1'b0; stuck_a = 1'b0;
        start_b = 1'b0; stop_b = 1'b0;
        start_c = 1'b0; stop_c = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_vec",   vec_a,   0);
        check("rst_valid", valid_a, 0);
        check("rst_exp",   exp_a,   0);
        check("rst_mm",    mm_a,    0);
        check("rst_err",   err_a,   0);
        check("rst_busy",  busy_a,  0);
        check("rst_done",  done_a,  0);
        $display("reset state checked");

        // Fault-free run
        run_a(0, -1);

        // Stuck-at-1 cell: the compares on vec=0, 1 and 2 fail
        stuck_a = 1'b1;
        check("a_done_held", done_a, 1);
        run_a(3, 20);

        // Abort at cycle 30, then restart
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("abort_restart_err", err_a, 0);
        repeat (30) @(negedge clk);
        stop_a = 1'b1;
        @(negedge clk);
        stop_a = 1'b0;
        check("abort_busy",  busy_a,  0);
        check("abort_valid", valid_a, 0);
        check("abort_done",  done_a,  0);
        check("abort_err",   err_a,   1);
        check("abort_mm",    mm_a,    0);
        repeat (3) @(negedge clk);
        check("abort_idle_busy", busy_a, 0);
        check("abort_idle_err",  err_a,  1);
        $display("abort: busy=%0d err_count=%0d", busy_a, err_a);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("restart_err",   err_a,   0);
        check("restart_vec",   vec_a,   0);
        check("restart_valid", valid_a, 1);

        // Asynchronous reset applied mid-run, between clock edges
        repeat (25) @(negedge clk);
        check("pre_rst_err", err_a, 1);
        check("pre_rst_vec", vec_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vec",   vec_a,   0);
        check("arst_valid", valid_a, 0);
        check("arst_exp",   exp_a,   0);
        check("arst_err",   err_a,   0);
        check("arst_busy",  busy_a,  0);
        check("arst_done",  done_a,  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy",  busy_a,  0);
        check("post_rst_valid", valid_a, 0);
        $display("async reset: busy=%0d vec_valid=%0d", busy_a, valid_a);

        // start and stop asserted together in IDLE: the block stays idle
        stuck_a = 1'b0;
        start_a = 1'b1;
        stop_a  = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        stop_a  = 1'b0;
        @(negedge clk);
        check("prio_busy",  busy_a,  0);
        check("prio_valid", valid_a, 0);
        $display("priority: busy=%0d", busy_a);

        // Loop wrap-around: HOLD=1, LOOPS=3
        mm_seen = 0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 0; c < 12; c++) begin
            check("b_vec",   vec_b,   c % 4);
            check("b_valid", valid_b, 1);
            check("b_done",  done_b,  0);
            if (mm_b) mm_seen++;
            @(negedge clk);
        end
        if (mm_b) mm_seen++;
        check("b_done_end", done_b,  1);
        check("b_busy_end", busy_b,  0);
        check("b_vec_end",  vec_b,   3);
        check("b_err",      err_b,   0);
        check("b_mm",       mm_seen, 0);
        $display("run B: done=%0d err_count=%0d", done_b, err_b);

        // Saturation: every compare fails, and the 4-bit counter stops at 15
        mm_seen = 0;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        for (int c = 0; c < 32; c++) begin
            if (c == 15) check("c_err_15", err_c, 15);
            if (mm_c) mm_seen++;
            @(negedge clk);
        end
        if (mm_c) mm_seen++;
        check("c_done", done_c,  1);
        check("c_err",  err_c,   15);
        check("c_mm",   mm_seen, 32);
        $display("run C: err_count=%0d pulses=%0d", err_c, mm_seen);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
